// File: rtl/oled_pkg.sv
// Shared definitions for the OLED power-up sequencer: FSM state encoding,
// init list length and SSD1306 command opcodes.
package oled_pkg;

   typedef enum logic [3:0] {
      ST_RST_HOLD,
      ST_RST_WAIT,
      ST_INIT_ISSUE,
      ST_INIT_WAIT,
      ST_PAGE_ISSUE,
      ST_PAGE_WAIT,
      ST_DATA_ISSUE,
      ST_DATA_WAIT,
      ST_DONE
   } state_t;

   localparam int INIT_LEN  = 27;
   localparam int PAGE_CMDS = 3;

   localparam logic [7:0] CMD_DISP_OFF     = 8'hAE;
   localparam logic [7:0] CMD_DISP_ON      = 8'hAF;
   localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
   localparam logic [7:0] CMD_CLK_DIV_VAL  = 8'h80;
   localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
   localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
   localparam logic [7:0] CMD_START_LINE   = 8'h40;
   localparam logic [7:0] CMD_CHG_PUMP     = 8'h8D;
   localparam logic [7:0] CMD_PUMP_ON      = 8'h14;
   localparam logic [7:0] CMD_ADDR_MODE    = 8'h20;
   localparam logic [7:0] CMD_PAGE_MODE    = 8'h02;
   localparam logic [7:0] CMD_SEG_NORMAL   = 8'hA0;
   localparam logic [7:0] CMD_SEG_REMAP    = 8'hA1;
   localparam logic [7:0] CMD_COM_SCAN_INC = 8'hC0;
   localparam logic [7:0] CMD_COM_SCAN_DEC = 8'hC8;
   localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
   localparam logic [7:0] CMD_CONTRAST     = 8'h81;
   localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
   localparam logic [7:0] CMD_PRECHG_VAL   = 8'hF1;
   localparam logic [7:0] CMD_VCOMH        = 8'hDB;
   localparam logic [7:0] CMD_VCOMH_VAL    = 8'h40;
   localparam logic [7:0] CMD_RESUME_RAM   = 8'hA4;
   localparam logic [7:0] CMD_NORMAL_DISP  = 8'hA6;
   localparam logic [7:0] CMD_SET_PAGE     = 8'hB0;
   localparam logic [7:0] CMD_COL_LO       = 8'h00;
   localparam logic [7:0] CMD_COL_HI       = 8'h10;
   localparam logic [7:0] CMD_NOP          = 8'hE3;

   // Page addressing preamble: select page, then reset column to 0 (low, high nibble).
   function automatic logic [7:0] page_cmd(input logic [2:0] page, input logic [1:0] sel);
      case (sel)
         2'd0:    return CMD_SET_PAGE | {5'b0_0000, page};
         2'd1:    return CMD_COL_LO;
         default: return CMD_COL_HI;
      endcase
   endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Combinational init command list for the OLED sequencer. Geometry-dependent
// entries (multiplex ratio, COM pin layout) follow PAGES; contrast is a parameter.
// Build option: OLED_FLIP_EN selects the 180-degree rotated segment/COM mapping.
module oled_init_rom #(
   parameter int         PAGES    = 8,
   parameter logic [7:0] CONTRAST = 8'hCF
) (
   input  logic [4:0] index,
   output logic [7:0] rom_byte
);
   import oled_pkg::*;

   localparam logic [7:0] MUX_VAL = 8'(8 * PAGES - 1);
   // Only the full 64-row panel uses the alternative COM pin configuration.
   localparam logic [7:0] COM_CFG = (PAGES == 8) ? 8'h12 : 8'h02;

`ifdef OLED_FLIP_EN
   localparam logic [7:0] SEG_CMD = CMD_SEG_NORMAL;
   localparam logic [7:0] COM_CMD = CMD_COM_SCAN_DEC;
`else
   localparam logic [7:0] SEG_CMD = CMD_SEG_REMAP;
   localparam logic [7:0] COM_CMD = CMD_COM_SCAN_INC;
`endif

   // Index to command byte lookup.
   always_comb begin
      rom_byte = CMD_NOP;
      case (index)
         5'd0:  rom_byte = CMD_DISP_OFF;
         5'd1:  rom_byte = CMD_CLK_DIV;
         5'd2:  rom_byte = CMD_CLK_DIV_VAL;
         5'd3:  rom_byte = CMD_MUX_RATIO;
         5'd4:  rom_byte = MUX_VAL;
         5'd5:  rom_byte = CMD_DISP_OFFSET;
         5'd6:  rom_byte = 8'h00;
         5'd7:  rom_byte = CMD_START_LINE;
         5'd8:  rom_byte = CMD_CHG_PUMP;
         5'd9:  rom_byte = CMD_PUMP_ON;
         5'd10: rom_byte = CMD_ADDR_MODE;
         5'd11: rom_byte = CMD_PAGE_MODE;
         5'd12: rom_byte = SEG_CMD;
         5'd13: rom_byte = COM_CMD;
         5'd14: rom_byte = CMD_COM_PINS;
         5'd15: rom_byte = COM_CFG;
         5'd16: rom_byte = CMD_CONTRAST;
         5'd17: rom_byte = CONTRAST;
         5'd18: rom_byte = CMD_PRECHARGE;
         5'd19: rom_byte = CMD_PRECHG_VAL;
         5'd20: rom_byte = CMD_VCOMH;
         5'd21: rom_byte = CMD_VCOMH_VAL;
         5'd22: rom_byte = CMD_RESUME_RAM;
         5'd23: rom_byte = CMD_NORMAL_DISP;
         5'd24: rom_byte = CMD_CHG_PUMP;
         5'd25: rom_byte = CMD_PUMP_ON;
         5'd26: rom_byte = CMD_DISP_ON;
         default: rom_byte = CMD_NOP;
      endcase
   end

endmodule

// File: rtl/oled_init_seq.sv
// SSD1306-class power-up sequencer: pulses panel reset, streams the init list,
// then clears every page with a latched fill byte through the SPI byte writer
// (ena_write / write_done handshake). init_done marks the hand-off point.
// Build option: OLED_FLIP_EN (rotated orientation, handled in oled_init_rom).
module oled_init_seq #(
   parameter int         RST_CYCLES  = 10,
   parameter int         WAIT_CYCLES = 10,
   parameter int         PAGES       = 8,
   parameter int         COLS        = 128,
   parameter logic [7:0] CONTRAST    = 8'hCF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] fill_pattern,
   input  logic       write_done,
   output logic       oled_rst,
   output logic       oled_dc,
   output logic [7:0] data,
   output logic       ena_write,
   output logic       busy,
   output logic       init_done
);
   import oled_pkg::*;

   localparam int TMAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int CW   = $clog2(COLS) + 1;

   localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [2:0]    PAGE_LAST = 3'(PAGES - 1);
   localparam logic [4:0]    INIT_LAST = 5'(INIT_LEN - 1);
   localparam logic [1:0]    CMD_LAST  = 2'(PAGE_CMDS - 1);

   state_t          state, state_nxt;
   logic [TW-1:0]   tmr, tmr_nxt;
   logic [4:0]      init_idx, init_nxt;
   logic [1:0]      cmd_idx, cmd_nxt;
   logic [2:0]      page_idx, page_nxt;
   logic [CW-1:0]   col_idx, col_nxt;
   logic [7:0]      fill_q;
   logic [7:0]      rom_byte;
   logic            ena_nxt;
   logic            dc_nxt;
   logic [7:0]      data_nxt;

   // The ROM is addressed with the next index so the byte is registered on the issue edge.
   oled_init_rom #(
      .PAGES    (PAGES),
      .CONTRAST (CONTRAST)
   ) u_rom (
      .index    (init_nxt),
      .rom_byte (rom_byte)
   );

   // Next-state, reset timers and byte/page/column counters.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      init_nxt  = init_idx;
      cmd_nxt   = cmd_idx;
      page_nxt  = page_idx;
      col_nxt   = col_idx;
      unique case (state)
         ST_RST_HOLD: begin
            if (tmr == RST_LAST) begin
               state_nxt = ST_RST_WAIT;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + TW'(1);
            end
         end
         ST_RST_WAIT: begin
            if (tmr == WAIT_LAST) begin
               state_nxt = ST_INIT_ISSUE;
               tmr_nxt   = '0;
               init_nxt  = '0;
            end else begin
               tmr_nxt = tmr + TW'(1);
            end
         end
         ST_INIT_ISSUE: state_nxt = ST_INIT_WAIT;
         ST_INIT_WAIT: begin
            if (write_done) begin
               if (init_idx == INIT_LAST) begin
                  state_nxt = ST_PAGE_ISSUE;
                  cmd_nxt   = '0;
                  page_nxt  = '0;
               end else begin
                  state_nxt = ST_INIT_ISSUE;
                  init_nxt  = init_idx + 5'd1;
               end
            end
         end
         ST_PAGE_ISSUE: state_nxt = ST_PAGE_WAIT;
         ST_PAGE_WAIT: begin
            if (write_done) begin
               if (cmd_idx == CMD_LAST) begin
                  state_nxt = ST_DATA_ISSUE;
                  col_nxt   = '0;
               end else begin
                  state_nxt = ST_PAGE_ISSUE;
                  cmd_nxt   = cmd_idx + 2'd1;
               end
            end
         end
         ST_DATA_ISSUE: state_nxt = ST_DATA_WAIT;
         ST_DATA_WAIT: begin
            if (write_done) begin
               if (col_idx == COL_LAST) begin
                  if (page_idx == PAGE_LAST) begin
                     state_nxt = ST_DONE;
                  end else begin
                     state_nxt = ST_PAGE_ISSUE;
                     page_nxt  = page_idx + 3'd1;
                     cmd_nxt   = '0;
                  end
               end else begin
                  state_nxt = ST_DATA_ISSUE;
                  col_nxt   = col_idx + CW'(1);
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nxt = ST_RST_HOLD;
               tmr_nxt   = '0;
               init_nxt  = '0;
               cmd_nxt   = '0;
               page_nxt  = '0;
               col_nxt   = '0;
            end
         end
         default: state_nxt = ST_RST_HOLD;
      endcase
   end

   // Byte selection for the write about to be issued; data/dc hold between writes.
   always_comb begin
      ena_nxt  = 1'b0;
      data_nxt = data;
      dc_nxt   = oled_dc;
      case (state_nxt)
         ST_INIT_ISSUE: begin
            ena_nxt  = 1'b1;
            data_nxt = rom_byte;
            dc_nxt   = 1'b0;
         end
         ST_PAGE_ISSUE: begin
            ena_nxt  = 1'b1;
            data_nxt = page_cmd(page_nxt, cmd_nxt);
            dc_nxt   = 1'b0;
         end
         ST_DATA_ISSUE: begin
            ena_nxt  = 1'b1;
            data_nxt = fill_q;
            dc_nxt   = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RST_HOLD;
         tmr       <= '0;
         init_idx  <= '0;
         cmd_idx   <= '0;
         page_idx  <= '0;
         col_idx   <= '0;
         oled_rst  <= 1'b0;
         oled_dc   <= 1'b0;
         data      <= 8'h00;
         ena_write <= 1'b0;
         busy      <= 1'b1;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         init_idx  <= init_nxt;
         cmd_idx   <= cmd_nxt;
         page_idx  <= page_nxt;
         col_idx   <= col_nxt;
         oled_rst  <= (state_nxt != ST_RST_HOLD);
         oled_dc   <= dc_nxt;
         data      <= data_nxt;
         ena_write <= ena_nxt;
         busy      <= (state_nxt != ST_DONE);
         init_done <= (state_nxt == ST_DONE);
      end
   end

   // Fill byte is captured on the first cycle of each reset hold and kept for the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= 8'h00;
      end else if (state == ST_RST_HOLD && tmr == '0) begin
         fill_q <= fill_pattern;
      end
   end

endmodule

// File: tb/tb_oled_init_seq.sv
// Bench for oled_init_seq: a default 128x64 instance and a 4-page/16-column
// instance run side by side, each with a randomized write_done responder and a
// per-cycle checker against a byte-stream model derived from the panel protocol.
module tb_oled_init_seq;

   localparam int RSTC  = 10;
   localparam int WAITC = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] fill_pattern;

   logic       wd     [2];
   logic       orst   [2];
   logic       dc     [2];
   logic [7:0] dat    [2];
   logic       ena    [2];
   logic       busy_v [2];
   logic       idone  [2];

   int         tests = 0;
   int         fails = 0;
   bit         done_f [2];
   int         idx_v  [2];
   int         lcnt   [2];
   logic [8:0] logb   [2][1075];
   bit         log_en;

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Expected {dc,data} of the k-th byte of a run, from the panel protocol.
   function automatic logic [8:0] exp_byte(input int k, input int pages, input int cols,
                                           input logic [7:0] fill);
      logic [7:0] seg, com;
      logic [7:0] tbl [27];
      int j, p, r;
`ifdef OLED_FLIP_EN
      seg = 8'hA0; com = 8'hC8;
`else
      seg = 8'hA1; com = 8'hC0;
`endif
      tbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'(8 * pages - 1), 8'hD3, 8'h00, 8'h40, 8'h8D,
              8'h14, 8'h20, 8'h02, seg, com, 8'hDA, ((pages == 8) ? 8'h12 : 8'h02),
              8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h8D, 8'h14, 8'hAF};
      if (k < 27) return {1'b0, tbl[k]};
      j = k - 27;
      p = j / (3 + cols);
      r = j % (3 + cols);
      if (r == 0) return {1'b0, 8'hB0 | 8'(p)};
      if (r == 1) return 9'h000;
      if (r == 2) return 9'h010;
      return {1'b1, fill};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int PG  = (g == 0) ? 8 : 4;
      localparam int CL  = (g == 0) ? 128 : 16;
      localparam int TOT = 27 + PG * (3 + CL);

      int         cyc;
      bit         rp;
      bit         prev_ena;
      logic [7:0] fillx;
      int         wd_cnt;
      int         hold_left;
      logic [8:0] e;

      oled_init_seq #(
         .RST_CYCLES  (RSTC),
         .WAIT_CYCLES (WAITC),
         .PAGES       (PG),
         .COLS        (CL),
         .CONTRAST    (8'hCF)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .start        (start),
         .fill_pattern (fill_pattern),
         .write_done   (wd[g]),
         .oled_rst     (orst[g]),
         .oled_dc      (dc[g]),
         .data         (dat[g]),
         .ena_write    (ena[g]),
         .busy         (busy_v[g]),
         .init_done    (idone[g])
      );

      // SPI writer stand-in: random ack latency, long hold-offs on the first data
      // bytes, and stray pulses where they must be ignored.
      initial begin
         wd[g]     = 1'b0;
         wd_cnt    = 0;
         hold_left = (g == 0) ? 3 : 0;
         forever begin
            @(negedge clk);
            wd[g] = 1'b0;
            if (!rst_n) begin
               wd_cnt = 0;
            end else begin
               if (wd_cnt > 0) begin
                  wd_cnt--;
                  if (wd_cnt == 0) wd[g] = 1'b1;
               end else if ((!busy_v[g] || !orst[g]) && $urandom_range(7) == 0) begin
                  wd[g] = 1'b1;
               end
               if (ena[g]) begin
                  if (hold_left > 0 && dc[g]) begin
                     wd_cnt = 50;
                     hold_left--;
                  end else begin
                     wd_cnt = $urandom_range(4, 1);
                  end
                  if (wd_cnt >= 3 && $urandom_range(3) == 0) wd[g] = 1'b1;
               end
            end
         end
      end

      // Per-cycle checker against the byte-stream model.
      initial begin
         cyc = 0; rp = 0; prev_ena = 0; fillx = 8'h00;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               chk({orst[g], dc[g], ena[g], busy_v[g], idone[g], dat[g]} == 13'b0_0_0_1_0_00000000,
                   "reset_outputs", {orst[g], dc[g], ena[g], busy_v[g], idone[g], dat[g]},
                   13'b0_0_0_1_0_00000000);
               cyc = 0; idx_v[g] = 0; done_f[g] = 0; rp = 0; prev_ena = 0;
               fillx = fill_pattern;
            end else begin
               if (rp) begin
                  cyc = 0; idx_v[g] = 0; done_f[g] = 0; rp = 0;
                  fillx = fill_pattern;
               end
               chk(orst[g] == (cyc >= RSTC), "oled_rst", orst[g], cyc >= RSTC);
               chk(busy_v[g] == !idone[g], "busy_vs_done", busy_v[g], !idone[g]);
               if (ena[g]) begin
                  chk(!prev_ena, "ena_one_cycle", prev_ena, 0);
                  if (idx_v[g] >= TOT) begin
                     chk(0, "extra_write", idx_v[g], TOT);
                  end else begin
                     e = exp_byte(idx_v[g], PG, CL, fillx);
                     chk({dc[g], dat[g]} == e, "byte", {idx_v[g][15:0], 3'b0, dc[g], dat[g]},
                         {idx_v[g][15:0], 3'b0, e});
                     if (idx_v[g] == 0) chk(cyc == RSTC + WAITC, "first_byte_cycle", cyc, RSTC + WAITC);
                     if (log_en) logb[g][idx_v[g]] = {dc[g], dat[g]};
                  end
                  idx_v[g]++;
               end
               if (idone[g] && !done_f[g]) begin
                  chk(idx_v[g] == TOT, "done_count", idx_v[g], TOT);
                  done_f[g] = 1;
                  if (log_en) lcnt[g] = idx_v[g];
               end else if (done_f[g]) begin
                  chk(idone[g], "done_hold", idone[g], 1);
               end
               if (start && done_f[g]) rp = 1;
               prev_ena = ena[g];
               cyc++;
            end
         end
      end
   end

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!(done_f[0] && done_f[1]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(done_f[0] && done_f[1], name, {done_f[0], done_f[1]}, 2'b11);
   endtask

   task automatic pulse_start(input logic [7:0] f);
      @(posedge clk);
      #1 fill_pattern = f;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin
      logic [7:0] seg_w, com_w;
      int n;
`ifdef OLED_FLIP_EN
      seg_w = 8'hA0; com_w = 8'hC8;
`else
      seg_w = 8'hA1; com_w = 8'hC0;
`endif
      rst_n = 1'b0;
      start = 1'b0;
      fill_pattern = 8'hAA;
      log_en = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;

      wait_done(15000, "run1_done");
      log_en = 1'b0;

      // Literal pins of the recorded first run.
      chk(lcnt[0] == 1075, "full_count", lcnt[0], 1075);
      chk(logb[0][0] == 9'h0AE, "first_byte", logb[0][0], 9'h0AE);
      chk(logb[0][12] == {1'b0, seg_w}, "seg_byte", logb[0][12], {1'b0, seg_w});
      chk(logb[0][13] == {1'b0, com_w}, "com_byte", logb[0][13], {1'b0, com_w});
      chk(logb[0][15] == 9'h012, "com_pins_64", logb[0][15], 9'h012);
      chk(logb[0][27] == 9'h0B0, "page0_cmd", logb[0][27], 9'h0B0);
      chk(logb[0][30] == 9'h1AA, "fill_first", logb[0][30], 9'h1AA);
      chk(logb[0][157] == 9'h1AA, "fill_last_p0", logb[0][157], 9'h1AA);
      chk(logb[0][158] == 9'h0B1, "page1_cmd", logb[0][158], 9'h0B1);
      chk(logb[0][944] == 9'h0B7, "page7_cmd", logb[0][944], 9'h0B7);
      chk(logb[0][1074] == 9'h1AA, "final_fill", logb[0][1074], 9'h1AA);
      chk(lcnt[1] == 103, "small_count", lcnt[1], 103);
      chk(logb[1][3] == 9'h0A8, "small_mux_cmd", logb[1][3], 9'h0A8);
      chk(logb[1][4] == 9'h01F, "small_mux_val", logb[1][4], 9'h01F);
      chk(logb[1][14] == 9'h0DA, "small_com_cmd", logb[1][14], 9'h0DA);
      chk(logb[1][15] == 9'h002, "small_com_val", logb[1][15], 9'h002);
      chk(logb[1][17] == 9'h0CF, "small_contrast", logb[1][17], 9'h0CF);
      chk(logb[1][26] == 9'h0AF, "small_disp_on", logb[1][26], 9'h0AF);
      chk(logb[1][102] == 9'h1AA, "small_last", logb[1][102], 9'h1AA);

      // Idle in DONE with stray write_done pulses; the checker flags any new write.
      repeat (40) @(posedge clk);
      #1;
      chk(idone[0] && idone[1] && !busy_v[0], "done_idle", {idone[0], idone[1], busy_v[0]}, 3'b110);

      // Re-run with a zero fill.
      pulse_start(8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk(busy_v[0] && !orst[0], "rerun_reset", {busy_v[0], orst[0]}, 2'b10);
      // Start while busy (and a new fill byte) must not disturb the run.
      repeat (300) @(posedge clk);
      pulse_start(8'h5A);
      wait_done(15000, "run2_done");

      // Random fill, then abort mid-data with an asynchronous reset.
      pulse_start(8'($urandom));
      n = 0;
      while (idx_v[0] <= 200 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(idx_v[0] > 200, "reach_data_phase", idx_v[0], 201);
      @(posedge clk);
      #1 fill_pattern = ~fill_pattern;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk(!orst[0] && !ena[0] && busy_v[0], "abort_async", {orst[0], ena[0], busy_v[0]}, 3'b001);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_done(15000, "run3_done");

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
